fsm_seq_arb: RTL and testbench
==============================

Name: fsm_seq_arb

Overview:
- Sequencer/arbiter that shares one 8-bit flag-reporting FSM unit between NumReq requesters.
- Accepts one operand per transaction over valid/ready, using round-robin arbitration.
- Drives the unit's data/start/stop controls, waits for its completion flag (with timeout), captures the 8-bit result, and returns it tagged with the requester ID over a valid/ready response channel.
- Sits between requester logic and the shared FSM datapath.

Parameters:
- NumReq, 2, number of requesters (2..8).
- TimeoutCycles, 15, maximum WAIT cycles before abort (1..255).
- IdW, $clog2(NumReq), width of requester ID (derived; do not override).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NumReq  per-requester request valid.
- req_data_i  in  NumReq x 8  per-requester operand.
- req_ready_o  out  NumReq  per-requester accept; one-hot or zero.
- unit_data_o  out  8  operand driven to the shared unit.
- unit_start_o  out  1  one-cycle start pulse to the unit.
- unit_stop_o  out  1  one-cycle abort pulse to the unit.
- unit_flag_i  in  1  unit completion flag.
- unit_result_i  in  8  unit result, valid while unit_flag_i=1.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accept.
- rsp_id_o  out  IdW  index of the requester served.
- rsp_data_o  out  8  captured result.
- rsp_timeout_o  out  1  transaction aborted by timeout.
- stat_done_o  out  16  completed-transaction count (optional feature).
- stat_timeout_o  out  16  timed-out-transaction count (optional feature).

Behaviour:
- Reset: every output is 0.
  - State IDLE; round-robin pointer last=NumReq-1, so requester 0 has first priority.
  - Timeout counter and result registers are 0.
- FSM states IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant = first asserted req_valid_i, searching from last+1 cyclically.
  - req_ready_o[grant]=1 combinationally; ready depends on valid.
  - On handshake: latch operand and ID, set last=grant, go to ISSUE.
  - All other states: req_ready_o=0.
- ISSUE (1 cycle):
  - unit_start_o=1, unit_data_o=latched operand.
  - unit_flag_i is ignored.
  - Go to WAIT with counter=0.
- WAIT:
  - unit_data_o holds the operand.
  - unit_flag_i=1: capture unit_result_i into rsp_data_o, rsp_timeout_o=0, go to RESP.
  - Else, if counter==TimeoutCycles-1: unit_stop_o=1 this cycle, rsp_data_o=0, rsp_timeout_o=1, go to RESP.
  - Else increment counter.
  - Flag and timeout in the same cycle: flag wins, no stop pulse.
- RESP:
  - rsp_valid_o=1; rsp_id_o, rsp_data_o and rsp_timeout_o stable until handshake.
  - On rsp_ready_i: go to IDLE. The next grant is possible the following cycle (no back-to-back IDLE bypass).
- unit_data_o=0 in IDLE and RESP.
- Latency: request accepted at cycle T -> start pulse at T+1 -> flag sampled from T+2. Flag at cycle F -> rsp_valid_o from F+1. Minimum accept-to-response 3 cycles.
- Only one transaction is outstanding at a time; no queueing.
- Requester lowering valid without ready: no effect, not granted.
- Asynchronous reset mid-transaction: return immediately to the reset state; no stop pulse is issued.

Optional Feature:
- Macro: FSM_SEQ_STATS_EN.
- Defined:
  - stat_done_o increments on each RESP handshake with rsp_timeout_o=0.
  - stat_timeout_o increments on each RESP handshake with rsp_timeout_o=1.
  - Both 16-bit, saturate at 0xFFFF, reset to 0.
- Undefined: both ports tied to 0 and no counter flops are instantiated.

Test Plan:
- Single request: req_valid_i=01, data 0x5A; unit flags 3 cycles after start with result 0xA5.
  - Required: start one cycle after accept, rsp_valid_o one cycle after flag.
  - Response: id=0, data=0xA5, timeout=0.
- Fairness: both requesters hold valid continuously for 4 transactions.
  - Required: grants 0,1,0,1; rsp_id_o sequence 0,1,0,1.
- Timeout: flag never asserts, TimeoutCycles=15.
  - Required: unit_stop_o pulses exactly once, in the 15th WAIT cycle.
  - Response: timeout=1, data=0x00.
- Simultaneous events: flag asserted in the last WAIT cycle, result 0x3C.
  - Required: no stop pulse; response data=0x3C, timeout=0.
- Backpressure: rsp_ready_i held low 5 cycles.
  - Required: response fields stable; req_ready_o=00 throughout even with valids high.
- Reset mid-WAIT: rst_ni pulsed low.
  - Required: all outputs 0 immediately; next grant goes to requester 0.
  - Stats build: after 3 done and 1 timeout, stat_done_o=3, stat_timeout_o=1.

Source files
------------

// File: rtl/fsm_seq_arb.sv
// fsm_seq_arb: round-robin sequencer sharing one flag-reporting FSM unit between NumReq requesters
// Ports: clk_i/rst_ni (async active-low); req_valid_i/req_data_i/req_ready_o request side;
// unit_data_o/unit_start_o/unit_stop_o/unit_flag_i/unit_result_i shared unit side;
// rsp_valid_o/rsp_ready_i/rsp_id_o/rsp_data_o/rsp_timeout_o response side;
// stat_done_o/stat_timeout_o counters, live only when FSM_SEQ_STATS_EN is defined.
module fsm_seq_arb #(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 15,
  parameter int IdW           = $clog2(NumReq)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  input  logic [NumReq-1:0][7:0] req_data_i,
  output logic [NumReq-1:0]      req_ready_o,
  output logic [7:0]             unit_data_o,
  output logic                   unit_start_o,
  output logic                   unit_stop_o,
  input  logic                   unit_flag_i,
  input  logic [7:0]             unit_result_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [IdW-1:0]         rsp_id_o,
  output logic [7:0]             rsp_data_o,
  output logic                   rsp_timeout_o,
  output logic [15:0]            stat_done_o,
  output logic [15:0]            stat_timeout_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e         state_q, state_d;
  logic [IdW-1:0] last_q, last_d, id_q, id_d, gnt, idx;
  logic [7:0]     op_q, op_d, data_q, data_d, cnt_q, cnt_d;
  logic           tmo_q, tmo_d, found, hit_limit;
  // first valid requester searching cyclically from last_q+1
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NumReq; i++) begin
      idx = IdW'((int'(last_q) + i) % NumReq);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end
  assign hit_limit = cnt_q == 8'(TimeoutCycles - 1);
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        last_d  = gnt;
        id_d    = gnt;
        op_d    = req_data_i[gnt];
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // a flag arriving in the final wait cycle still wins over the abort
        state_d = (unit_flag_i || hit_limit) ? RESP : WAIT;
        data_d  = unit_flag_i ? unit_result_i : (hit_limit ? '0 : data_q);
        tmo_d   = unit_flag_i ? 1'b0 : (hit_limit ? 1'b1 : tmo_q);
        cnt_d   = cnt_q + 8'd1;
      end
      RESP: state_d = rsp_ready_i ? IDLE : RESP;
    endcase
  end
  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && found) req_ready_o[gnt] = 1'b1;
    unit_start_o = state_q == ISSUE;
    unit_data_o  = (state_q == ISSUE || state_q == WAIT) ? op_q : '0;
    unit_stop_o  = state_q == WAIT && !unit_flag_i && hit_limit;
    rsp_valid_o  = state_q == RESP;
  end
  assign rsp_id_o      = id_q;
  assign rsp_data_o    = data_q;
  assign rsp_timeout_o = tmo_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= IdW'(NumReq - 1);
      id_q    <= '0;
      op_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end
`ifdef FSM_SEQ_STATS_EN
  logic [15:0] done_q, done_d, tout_q, tout_d;
  logic        rsp_hs;
  always_comb begin
    rsp_hs = state_q == RESP && rsp_ready_i;
    done_d = (rsp_hs && !tmo_q && done_q != 16'hFFFF) ? done_q + 16'd1 : done_q;
    tout_d = (rsp_hs && tmo_q && tout_q != 16'hFFFF) ? tout_q + 16'd1 : tout_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= '0;
      tout_q <= '0;
    end else begin
      done_q <= done_d;
      tout_q <= tout_d;
    end
  end
  assign stat_done_o    = done_q;
  assign stat_timeout_o = tout_q;
`else
  assign stat_done_o    = '0;
  assign stat_timeout_o = '0;
`endif
endmodule

// File: tb/tb_fsm_seq_arb.sv
// tb_fsm_seq_arb: vector table, directed corner sequences and random traffic against a reference model
module tb_fsm_seq_arb;
  localparam int T = 15;
`ifdef FSM_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst_ni = 1'b0;
  logic [1:0] rv = '0, req_ready_o;
  logic [1:0][7:0] rd = '0;
  logic flag = 1'b0, rsp_ready = 1'b0;
  logic [7:0] res = '0, unit_data_o, rsp_data_o;
  logic unit_start_o, unit_stop_o, rsp_valid_o, rsp_timeout_o;
  logic [0:0] rsp_id_o;
  logic [15:0] stat_done_o, stat_timeout_o;
  int nchk = 0, nerr = 0, last = 1, ndone = 0, ntmo = 0;
  fsm_seq_arb dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(rv), .req_data_i(rd), .req_ready_o(req_ready_o),
    .unit_data_o(unit_data_o), .unit_start_o(unit_start_o), .unit_stop_o(unit_stop_o),
    .unit_flag_i(flag), .unit_result_i(res), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o), .rsp_timeout_o(rsp_timeout_o),
    .stat_done_o(stat_done_o), .stat_timeout_o(stat_timeout_o)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end
  typedef struct {
    logic [1:0] v; logic [7:0] op; int d; logic [7:0] r; int bp; bit hold;
    int id; logic [7:0] data; bit tmo;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string n, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, int'(req_ready_o), 0);
    chk({tag, "_start"}, int'(unit_start_o), 0);
    chk({tag, "_stop"}, int'(unit_stop_o), 0);
    chk({tag, "_udata"}, int'(unit_data_o), 0);
    chk({tag, "_rvalid"}, int'(rsp_valid_o), 0);
    chk({tag, "_rid"}, int'(rsp_id_o), 0);
    chk({tag, "_rdata"}, int'(rsp_data_o), 0);
    chk({tag, "_rtmo"}, int'(rsp_timeout_o), 0);
    chk({tag, "_sdone"}, int'(stat_done_o), 0);
    chk({tag, "_stmo"}, int'(stat_timeout_o), 0);
  endtask
  task automatic chk_stats(input string tag);
    chk({tag, "_done"}, int'(stat_done_o), STATS ? ndone : 0);
    chk({tag, "_tmo"}, int'(stat_timeout_o), STATS ? ntmo : 0);
  endtask
  function automatic int exp_grant();
    for (int i = 1; i <= 2; i++) if (rv[(last + i) % 2]) return (last + i) % 2;
    return -1;
  endfunction
  // one whole transaction; d = cycles from start to flag (0 = never)
  task automatic txn(input int d, input logic [7:0] r, input int bp, input bit hold,
                     input int eid, input logic [7:0] eop, input logic [7:0] edata, input bit etmo);
    int stops = 0;
    bit done = 0;
    #1;
    chk("grant_ready", int'(req_ready_o), 1 << eid);
    cyc();
    if (!hold) rv[eid] = 1'b0;
    flag = 1'($urandom_range(0, 1));
    res = 8'($urandom);
    #1;
    chk("start", int'(unit_start_o), 1);
    chk("start_data", int'(unit_data_o), int'(eop));
    chk("busy_ready", int'(req_ready_o), 0);
    for (int k = 0; k < T + 4 && !done; k++) begin
      cyc();
      flag = (k == d - 1);
      res = flag ? r : 8'($urandom);
      #1;
      chk("wait_data", int'(unit_data_o), int'(eop));
      stops += int'(unit_stop_o);
      if (unit_stop_o) chk("stop_cycle", k, T - 1);
      done = flag || unit_stop_o;
    end
    chk("wait_bound", int'(done), 1);
    chk("stop_count", stops, int'(etmo));
    cyc();
    flag = 1'b0;
    #1;
    for (int b = 0; b <= bp; b++) begin
      if (b > 0) begin
        cyc();
        #1;
        chk("bp_ready", int'(req_ready_o), 0);
      end
      chk("rsp_valid", int'(rsp_valid_o), 1);
      chk("rsp_id", int'(rsp_id_o), eid);
      chk("rsp_data", int'(rsp_data_o), int'(edata));
      chk("rsp_tmo", int'(rsp_timeout_o), int'(etmo));
      chk("resp_udata", int'(unit_data_o), 0);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    last = eid;
    if (etmo) ntmo++; else ndone++;
    #1;
    chk("rsp_drop", int'(rsp_valid_o), 0);
  endtask
  initial begin
    tbl[0] = '{2'b11, 8'h11, 2, 8'hE1, 0, 1, 0, 8'hE1, 0};
    tbl[1] = '{2'b11, 8'h11, 2, 8'hE2, 0, 1, 1, 8'hE2, 0};
    tbl[2] = '{2'b11, 8'h11, 2, 8'hE3, 0, 1, 0, 8'hE3, 0};
    tbl[3] = '{2'b11, 8'h11, 2, 8'hE4, 0, 1, 1, 8'hE4, 0};
    tbl[4] = '{2'b01, 8'h5A, 3, 8'hA5, 0, 0, 0, 8'hA5, 0};
    tbl[5] = '{2'b10, 8'h70, 0, 8'hFF, 0, 0, 1, 8'h00, 1};
    tbl[6] = '{2'b01, 8'h30, 15, 8'h3C, 0, 0, 0, 8'h3C, 0};
    tbl[7] = '{2'b11, 8'h90, 4, 8'h99, 5, 1, 1, 8'h99, 0};
    tbl[8] = '{2'b10, 8'hC0, 1, 8'hC3, 0, 0, 1, 8'hC3, 0};
    tbl[9] = '{2'b01, 8'h00, 16, 8'h77, 1, 0, 0, 8'h00, 1};
    #3;
    chk_quiet("reset");
    #9;
    rst_ni = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      rv = tbl[i].v;
      rd[0] = tbl[i].op;
      rd[1] = tbl[i].op + 8'd1;
      txn(tbl[i].d, tbl[i].r, tbl[i].bp, tbl[i].hold, tbl[i].id,
          tbl[i].op + 8'(tbl[i].id), tbl[i].data, tbl[i].tmo);
    end
    chk_stats("table_stats");
    rv = 2'b10;
    rd[1] = 8'h44;
    #1;
    chk("mid_ready", int'(req_ready_o), 2);
    cyc();
    rv = 2'b00;
    cyc();
    cyc();
    #1;
    chk("mid_in_wait", int'(unit_data_o), 8'h44);
    rst_ni = 1'b0;
    #1;
    chk_quiet("mid_reset");
    rst_ni = 1'b1;
    last = 1;
    ndone = 0;
    ntmo = 0;
    rv = 2'b11;
    rd[0] = 8'h01;
    rd[1] = 8'h02;
    txn(2, 8'h10, 0, 0, 0, 8'h01, 8'h10, 0);
    txn(5, 8'h20, 1, 0, 1, 8'h02, 8'h20, 0);
    rv = 2'b01;
    rd[0] = 8'h03;
    txn(0, 8'h30, 0, 0, 0, 8'h03, 8'h00, 1);
    rv = 2'b10;
    rd[1] = 8'h04;
    txn(9, 8'h40, 0, 0, 1, 8'h04, 8'h40, 0);
    chk_stats("stats_3_1");
    for (int n = 0; n < 40; n++) begin
      int g, d;
      logic [7:0] r;
      bit tmo;
      for (int j = 0; j < 2; j++)
        if (!rv[j] && $urandom_range(0, 1) == 1) begin
          rv[j] = 1'b1;
          rd[j] = 8'($urandom);
        end
      if (rv == 2'b00) rv[$urandom_range(0, 1)] = 1'b1;
      g = exp_grant();
      d = $urandom_range(0, T + 2);
      r = 8'($urandom);
      tmo = (d == 0) || (d > T);
      txn(d, r, $urandom_range(0, 2), 0, g, rd[g], tmo ? 8'h00 : r, tmo);
    end
    chk_stats("random_stats");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
